// File: rtl/sync_frame_pkg.sv
// sync_frame_pkg
//   Definitions shared by the sync-header inserter and the block interleaver.
//   Both blocks import this package, so their frame length always agrees.
//   Contents: sync marker and repetition count, frame composition
//   (sync + payload + pad), default interleaver geometry, and the
//   interleaver reader state encoding.
package sync_frame_pkg;

  // 64-bit sync marker, sent SYNC_REPETITION times at the start of every frame
  localparam logic [63:0] SYNC_MARKER     = 64'h1ACF_FC1D_5A5A_A5A5;
  localparam int          SYNC_REPETITION = 32'd3;
  localparam int          SYNC_LEN_BYTES  = 32'd8 * SYNC_REPETITION;
  localparam int          PAYLOAD_LEN     = 32'd255;
  localparam int          PADDING_LEN     = 32'd1;
  localparam int          FRAME_LEN       = SYNC_LEN_BYTES + PAYLOAD_LEN + PADDING_LEN;

  // Default interleaver geometry; ROWS * COLS must equal FRAME_LEN
  localparam int          DEFAULT_ROWS    = 32'd14;
  localparam int          DEFAULT_COLS    = 32'd20;

  // Interleaver reader states
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_RUN   = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/interleave_bank_ram.sv
// interleave_bank_ram
//   Simple dual-port RAM holding both interleaver banks (2 x DEPTH bytes).
//   The bank select is the most significant part of each address.
//   The read is registered and has a latency of one cycle. This shape is BRAM-inferable.
// Ports:
//   clk          clock
//   we           write enable
//   wbank/waddr  write bank and byte address within the bank
//   wdata        write byte
//   re           read enable
//   rbank/raddr  read bank and byte address within the bank
//   rdata        read byte, valid the cycle after re
module interleave_bank_ram #(
  parameter int DEPTH = 280,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [0:1][0:DEPTH-1];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wbank][waddr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[rbank][raddr];
    end
  end

endmodule

// File: rtl/block_interleaver.sv
// block_interleaver
//   Row/column byte interleaver for fixed-length frames (ROWS*COLS bytes).
//   The block writes each frame row-wise into one bank of a ping-pong buffer and
//   reads it back column-wise. It adds tlast on the last byte of each output frame.
//   Frame boundaries come from counting accepted bytes only.
// Ports:
//   core_clk, rst                          clock, synchronous active-high reset
//   s_axis_input_tdata/tvalid/tready       input byte stream (no tlast)
//   m_axis_output_tdata/tvalid/tlast/tready interleaved output stream
module block_interleaver
  import sync_frame_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,   // >= 2
  parameter int COLS = DEFAULT_COLS    // >= 2
) (
  input  logic       core_clk,
  input  logic       rst,
  input  logic [7:0] s_axis_input_tdata,
  input  logic       s_axis_input_tvalid,
  output logic       s_axis_input_tready,
  output logic [7:0] m_axis_output_tdata,
  output logic       m_axis_output_tvalid,
  output logic       m_axis_output_tlast,
  input  logic       m_axis_output_tready
);

  // Bytes per frame; must equal sync_frame_pkg::FRAME_LEN when used behind the sync inserter
  localparam int FRAME_BYTES = ROWS * COLS;
  localparam int AW = $clog2(FRAME_BYTES);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [AW-1:0] WR_LAST   = AW'(FRAME_BYTES - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  // Going down a column adds COLS. Wrapping from the bottom row to the top of the
  // next column subtracts (ROWS-1)*COLS - 1.
  localparam logic [AW-1:0] ADDR_STEP = AW'(COLS);
  localparam logic [AW-1:0] ADDR_WRAP = AW'((ROWS - 1) * COLS - 1);

  // writer / bank ownership
  logic [AW-1:0] wcnt_r;
  logic          wsel_r;
  logic          rsel_r;
  logic [1:0]    full_r;
  logic          in_ready_r;
  logic          wr_fire_s;
  logic          frame_in_done_s;
  logic [1:0]    full_nxt_s;
  logic          wsel_nxt_s;

  // reader
  rd_state_e     state_r, state_nxt_s;
  logic [RW-1:0] rrow_r;
  logic [CW-1:0] rcol_r;
  logic [AW-1:0] raddr_r;
  logic          issue_s;
  logic          issue_last_s;
  logic          room_s;
  logic [7:0]    rd_data_s;

  // output FIFO. A word still in the RAM read register is also presented as the
  // head when the FIFO is empty, so the first byte appears one cycle after its read.
  logic          inflight_r;
  logic          inflight_last_r;
  logic [1:0]    count_r;
  logic [1:0]    count_nxt_s;
  logic [7:0]    fifo0_data_r, fifo1_data_r;
  logic          fifo0_last_r, fifo1_last_r;
  logic          tvalid_s;
  logic          pop_s;
  logic          fifo_pop_s;
  logic          push_s;
  logic          push_idx_s;
  logic [2:0]    occ_s;
  logic [7:0]    head_data_s;
  logic          head_last_s;
  logic          last_pop_s;

  assign s_axis_input_tready  = in_ready_r;
  assign wr_fire_s            = s_axis_input_tvalid && in_ready_r;
  assign frame_in_done_s      = wr_fire_s && (wcnt_r == WR_LAST);

  assign tvalid_s             = (count_r != 2'd0) || inflight_r;
  assign pop_s                = tvalid_s && m_axis_output_tready;
  assign fifo_pop_s           = pop_s && (count_r != 2'd0);
  // The in-flight word goes straight out when the FIFO is empty and the head pops.
  assign push_s               = inflight_r && !(pop_s && (count_r == 2'd0));
  assign push_idx_s           = !((count_r == 2'd0) || ((count_r == 2'd1) && fifo_pop_s));
  assign count_nxt_s          = count_r + {1'b0, push_s} - {1'b0, fifo_pop_s};
  assign last_pop_s           = pop_s && head_last_s && (state_r == R_DRAIN);

  // Occupancy after this cycle's pop must leave room for one more read.
  assign occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign room_s  = (occ_s < 3'd2);
  // A full bank is read starting in the same cycle the reader sees it, even in R_IDLE.
  assign issue_s = room_s && ((state_r == R_RUN) || ((state_r == R_IDLE) && full_r[rsel_r]));
  assign issue_last_s = issue_s && (rrow_r == ROW_LAST) && (rcol_r == COL_LAST);

  assign m_axis_output_tvalid = tvalid_s;
  assign m_axis_output_tdata  = head_data_s;
  assign m_axis_output_tlast  = head_last_s;

  interleave_bank_ram #(
    .DEPTH (FRAME_BYTES),
    .AW    (AW)
  ) u_ram (
    .clk   (core_clk),
    .we    (wr_fire_s),
    .wbank (wsel_r),
    .waddr (wcnt_r),
    .wdata (s_axis_input_tdata),
    .re    (issue_s),
    .rbank (rsel_r),
    .raddr (raddr_r),
    .rdata (rd_data_s)
  );

  // next bank flags: writer fills one bank while reader frees the other, both may act at once
  always_comb begin
    full_nxt_s = full_r;
    if (frame_in_done_s) begin
      full_nxt_s[wsel_r] = 1'b1;
    end else begin
      full_nxt_s[wsel_r] = full_r[wsel_r];
    end
    if (last_pop_s) begin
      full_nxt_s[rsel_r] = 1'b0;
    end else begin
      full_nxt_s[rsel_r] = full_nxt_s[rsel_r];
    end
    wsel_nxt_s = frame_in_done_s ? ~wsel_r : wsel_r;
  end

  // writer counter, bank flags, bank selects and registered input ready
  always_ff @(posedge core_clk) begin
    if (rst) begin
      wcnt_r     <= '0;
      wsel_r     <= 1'b0;
      rsel_r     <= 1'b0;
      full_r     <= 2'b00;
      in_ready_r <= 1'b1;
    end else begin
      if (frame_in_done_s) begin
        wcnt_r <= '0;
      end else if (wr_fire_s) begin
        wcnt_r <= wcnt_r + AW'(1);
      end
      wsel_r     <= wsel_nxt_s;
      rsel_r     <= last_pop_s ? ~rsel_r : rsel_r;
      full_r     <= full_nxt_s;
      in_ready_r <= ~full_nxt_s[wsel_nxt_s];
    end
  end

  // reader next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      R_IDLE: begin
        if (full_r[rsel_r]) begin
          state_nxt_s = R_RUN;
        end else begin
          state_nxt_s = R_IDLE;
        end
      end
      R_RUN: begin
        if (issue_last_s) begin
          state_nxt_s = R_DRAIN;
        end else begin
          state_nxt_s = R_RUN;
        end
      end
      R_DRAIN: begin
        if (last_pop_s) begin
          state_nxt_s = full_r[~rsel_r] ? R_RUN : R_IDLE;
        end else begin
          state_nxt_s = R_DRAIN;
        end
      end
      default: begin
        state_nxt_s = R_IDLE;
      end
    endcase
  end

  // reader state register
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_r <= R_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // column-wise read address: row/col counters with an incrementally held address
  always_ff @(posedge core_clk) begin
    if (rst) begin
      rrow_r  <= '0;
      rcol_r  <= '0;
      raddr_r <= '0;
    end else if (issue_s) begin
      if (issue_last_s) begin
        rrow_r  <= '0;
        rcol_r  <= '0;
        raddr_r <= '0;
      end else if (rrow_r == ROW_LAST) begin
        rrow_r  <= '0;
        rcol_r  <= rcol_r + CW'(1);
        raddr_r <= raddr_r - ADDR_WRAP;
      end else begin
        rrow_r  <= rrow_r + RW'(1);
        raddr_r <= raddr_r + ADDR_STEP;
      end
    end
  end

  // output head: FIFO entry 0, else the word in the RAM read register, else zero
  always_comb begin
    if (count_r != 2'd0) begin
      head_data_s = fifo0_data_r;
      head_last_s = fifo0_last_r;
    end else if (inflight_r) begin
      head_data_s = rd_data_s;
      head_last_s = inflight_last_r;
    end else begin
      head_data_s = 8'h00;
      head_last_s = 1'b0;
    end
  end

  // output FIFO: shift on pop, then absorb the word returned by the RAM
  always_ff @(posedge core_clk) begin
    if (rst) begin
      fifo0_data_r    <= 8'h00;
      fifo1_data_r    <= 8'h00;
      fifo0_last_r    <= 1'b0;
      fifo1_last_r    <= 1'b0;
      count_r         <= 2'd0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      if (fifo_pop_s) begin
        fifo0_data_r <= fifo1_data_r;
        fifo0_last_r <= fifo1_last_r;
      end
      if (push_s) begin
        if (push_idx_s) begin
          fifo1_data_r <= rd_data_s;
          fifo1_last_r <= inflight_last_r;
        end else begin
          fifo0_data_r <= rd_data_s;
          fifo0_last_r <= inflight_last_r;
        end
      end
      count_r         <= count_nxt_s;
      inflight_r      <= issue_s;
      inflight_last_r <= issue_last_s;
    end
  end

endmodule

// File: tb/tb_block_interleaver.sv
// tb_block_interleaver
//   Directed bench for block_interleaver (ROWS=14, COLS=20). Input frame f, byte n
//   carries (n + 7*f) mod 256. The expected output byte k of a frame is the input
//   byte at row (k mod 14) and column (k div 14).
module tb_block_interleaver;

  localparam int ROWS = 14;
  localparam int COLS = 20;
  localparam int FLEN = 280;

  logic       core_clk;
  logic       rst;
  logic [7:0] s_axis_input_tdata;
  logic       s_axis_input_tvalid;
  logic       s_axis_input_tready;
  logic [7:0] m_axis_output_tdata;
  logic       m_axis_output_tvalid;
  logic       m_axis_output_tlast;
  logic       m_axis_output_tready;

  block_interleaver dut (
    .core_clk             (core_clk),
    .rst                  (rst),
    .s_axis_input_tdata   (s_axis_input_tdata),
    .s_axis_input_tvalid  (s_axis_input_tvalid),
    .s_axis_input_tready  (s_axis_input_tready),
    .m_axis_output_tdata  (m_axis_output_tdata),
    .m_axis_output_tvalid (m_axis_output_tvalid),
    .m_axis_output_tlast  (m_axis_output_tlast),
    .m_axis_output_tready (m_axis_output_tready)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus / model state
  int in_frames, vpct, rpct;
  int in_f, in_n, out_f, out_k;
  int cyc;
  int last_in_cyc, first_valid_cyc, tlast_cyc, tlast_cnt;
  int lo_run, lo_max;
  bit hold_prev;
  logic [7:0] hold_data;
  logic       hold_last;
  logic [7:0] first_frame [0:FLEN-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] in_byte(input int f, input int n);
    return 8'((n + 7 * f) % 256);
  endfunction

  function automatic logic [7:0] exp_byte(input int f, input int k);
    return in_byte(f, (k % ROWS) * COLS + (k / ROWS));
  endfunction

  // one clock cycle: drive, observe, update model, advance to #1 after next edge
  task automatic step();
    bit in_fire, out_fire;
    s_axis_input_tvalid  = (in_f < in_frames) && ($urandom_range(99) < 32'(vpct));
    s_axis_input_tdata   = in_byte(in_f, in_n);
    m_axis_output_tready = ($urandom_range(99) < 32'(rpct));
    if (hold_prev) begin
      check_val("hold_valid", 32'(m_axis_output_tvalid), 32'd1);
      check_val("hold_data", 32'(m_axis_output_tdata), 32'(hold_data));
      check_val("hold_last", 32'(m_axis_output_tlast), 32'(hold_last));
    end
    in_fire  = s_axis_input_tvalid && s_axis_input_tready;
    out_fire = m_axis_output_tvalid && m_axis_output_tready;
    if ((in_f < in_frames) && !s_axis_input_tready) begin
      lo_run++;
      if (lo_run > lo_max) lo_max = lo_run;
    end else begin
      lo_run = 0;
    end
    if (m_axis_output_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (in_fire) begin
      if (in_n == FLEN - 1) begin
        last_in_cyc = cyc;
        in_n = 0;
        in_f++;
      end else begin
        in_n++;
      end
    end
    if (out_fire) begin
      check_val("data", 32'(m_axis_output_tdata), 32'(exp_byte(out_f, out_k)));
      check_val("tlast", 32'(m_axis_output_tlast), (out_k == FLEN - 1) ? 32'd1 : 32'd0);
      if (out_f == 0) first_frame[out_k] = m_axis_output_tdata;
      if (m_axis_output_tlast) begin
        tlast_cnt++;
        tlast_cyc = cyc;
      end
      if (out_k == FLEN - 1) begin
        out_k = 0;
        out_f++;
      end else begin
        out_k++;
      end
    end
    hold_prev = m_axis_output_tvalid && !m_axis_output_tready;
    hold_data = m_axis_output_tdata;
    hold_last = m_axis_output_tlast;
    @(posedge core_clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s_axis_input_tvalid  = 1'b0;
    s_axis_input_tdata   = 8'h00;
    m_axis_output_tready = 1'b0;
    @(posedge core_clk);
    #1;
    cyc++;
    rst = 1'b0;
    in_f = 0; in_n = 0; out_f = 0; out_k = 0;
    first_valid_cyc = -1; last_in_cyc = -1; tlast_cyc = -1; tlast_cnt = 0;
    lo_run = 0; lo_max = 0; hold_prev = 1'b0;
  endtask

  task automatic run_until_out(input string tag, input int frames, input int budget);
    int n = 0;
    while (out_f < frames && n < budget) begin
      step();
      n++;
    end
    check_val(tag, 32'(out_f), 32'(frames));
  endtask

  initial begin
    int n;
    cyc = 0;
    in_frames = 0; vpct = 100; rpct = 100;
    apply_reset();
    apply_reset();

    // reset state
    check_val("rst_in_ready", 32'(s_axis_input_tready), 32'd1);
    check_val("rst_out_valid", 32'(m_axis_output_tvalid), 32'd0);
    check_val("rst_out_last", 32'(m_axis_output_tlast), 32'd0);
    check_val("rst_out_data", 32'(m_axis_output_tdata), 32'd0);

    // single frame, values = index, latency and key output bytes
    in_frames = 1; vpct = 100; rpct = 100;
    run_until_out("s1_frames", 1, 1000);
    check_val("s1_latency", 32'(first_valid_cyc - last_in_cyc), 32'd2);
    check_val("s1_k0", 32'(first_frame[0]), 32'h00);
    check_val("s1_k1", 32'(first_frame[1]), 32'h14);
    check_val("s1_k3", 32'(first_frame[3]), 32'h3C);
    check_val("s1_k14", 32'(first_frame[14]), 32'h01);
    check_val("s1_k279", 32'(first_frame[279]), 32'h17);
    check_val("s1_tlast_cnt", 32'(tlast_cnt), 32'd1);

    // four back-to-back frames at full rate
    apply_reset();
    in_frames = 4; vpct = 100; rpct = 100;
    run_until_out("s2_frames", 4, 2500);
    check_val("s2_rdy_low_le3", (lo_max <= 3) ? 32'd1 : 32'd0, 32'd1);
    check_val("s2_tlast_cnt", 32'(tlast_cnt), 32'd4);

    // backpressure: both banks fill, head byte held
    apply_reset();
    in_frames = 3; vpct = 100; rpct = 0;
    for (int i = 0; i < 700; i++) step();
    check_val("s3_accepted", 32'(in_f * FLEN + in_n), 32'd560);
    check_val("s3_in_ready", 32'(s_axis_input_tready), 32'd0);
    check_val("s3_valid", 32'(m_axis_output_tvalid), 32'd1);
    check_val("s3_data", 32'(m_axis_output_tdata), 32'h00);
    check_val("s3_last", 32'(m_axis_output_tlast), 32'd0);
    rpct = 100;
    n = 0;
    while (tlast_cnt < 1 && n < 1000) begin step(); n++; end
    check_val("s3_first_tlast", 32'(tlast_cnt), 32'd1);
    n = 0;
    while (!s_axis_input_tready && n < 10) begin step(); n++; end
    check_val("s3_rdy_restore", (cyc - tlast_cyc <= 2 && s_axis_input_tready) ? 32'd1 : 32'd0, 32'd1);
    run_until_out("s3_frames", 3, 2000);

    // random valid/ready, 50 frames
    apply_reset();
    in_frames = 50; vpct = 50; rpct = 50;
    run_until_out("s4_frames", 50, 60000);
    check_val("s4_tlast_cnt", 32'(tlast_cnt), 32'd50);

    // reset in the middle of traffic
    apply_reset();
    in_frames = 2; vpct = 100; rpct = 0;
    n = 0;
    while (!(in_f == 1 && in_n == 100) && n < 1000) begin step(); n++; end
    check_val("s5_in_pos", 32'(in_f * FLEN + in_n), 32'd380);
    vpct = 0; rpct = 100;
    n = 0;
    while (out_k < 10 && n < 100) begin step(); n++; end
    check_val("s5_out_pos", 32'(out_k), 32'd10);
    apply_reset();
    check_val("s5_rst_valid", 32'(m_axis_output_tvalid), 32'd0);
    check_val("s5_rst_ready", 32'(s_axis_input_tready), 32'd1);
    in_frames = 1; vpct = 100; rpct = 100;
    run_until_out("s5_frames", 1, 1000);
    check_val("s5_k14", 32'(first_frame[14]), 32'h01);
    check_val("s5_k279", 32'(first_frame[279]), 32'h17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
